rf_alu_sequencer: RTL and testbench

- Multi-cycle execute/write-back sequencer that sits directly downstream and upstream of the 32x32 register file.
- Accepts one R-type command (op, rs1, rs2, rd) per valid/ready handshake and drives the register file read ports.
- Captures the registered read data, computes the ALU result, then drives the register file write port for exactly one cycle.
- Replaces the hand-sequenced read-add-write flow used in register-file benches with a reusable stage.

---
 rtl/rf_seq_pkg.sv | 25 ++
 rtl/rf_seq_alu.sv | 37 +++
 rtl/rf_alu_sequencer.sv | 110 +++++++++++
 tb/tb_rf_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file execute/write-back sequencer:
// op codes, FSM state encoding and default sizes.
package rf_seq_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rf_seq_alu.sv
// Purely combinational ALU used by the sequencer; kept separate so later
// datapath blocks can reuse the same op decoding.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [2:0]       op,
    output logic [width-1:0] result
);

    localparam int SHIFT_BITS = $clog2(width);

    logic [SHIFT_BITS-1:0] shift_amount;
    logic                  less_than;

    assign shift_amount = b[SHIFT_BITS-1:0];
    assign less_than    = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(width-1){1'b0}}, less_than};
            OP_SLL:  result = a << shift_amount;
            OP_SRL:  result = a >> shift_amount;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Read / execute / write-back sequencer sitting around a registered-read 32x32
// register file. Optional macro RF_SEQ_X0_HARDWIRE_EN makes r0 a hardwired zero.
module rf_alu_sequencer
    import rf_seq_pkg::*;
#(
    parameter int width      = DEFAULT_WIDTH,
    parameter int addr_width = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic [2:0]            cmdOp,
    input  logic [addr_width-1:0] cmdRs1,
    input  logic [addr_width-1:0] cmdRs2,
    input  logic [addr_width-1:0] cmdRd,
    output logic [addr_width-1:0] readRegister1,
    output logic [addr_width-1:0] readRegister2,
    input  logic [width-1:0]      readData1,
    input  logic [width-1:0]      readData2,
    output logic [addr_width-1:0] writeRegister,
    output logic [width-1:0]      writeData,
    output logic                  regWrite,
    output logic                  doneValid,
    output logic [width-1:0]      doneResult,
    output logic                  doneZero
);

    state_t                state;
    logic [2:0]            op;
    logic [addr_width-1:0] rs1;
    logic [addr_width-1:0] rs2;
    logic [addr_width-1:0] rd;
    logic [width-1:0]      result;
    logic [width-1:0]      done_result;
    logic                  done_zero;
    logic [width-1:0]      operand_a;
    logic [width-1:0]      operand_b;
    logic [width-1:0]      alu_result;
    logic                  write_allowed;

`ifdef RF_SEQ_X0_HARDWIRE_EN
    assign operand_a     = (rs1 == '0) ? '0 : readData1;
    assign operand_b     = (rs2 == '0) ? '0 : readData2;
    assign write_allowed = (rd != '0);
`else
    assign operand_a     = readData1;
    assign operand_b     = readData2;
    assign write_allowed = 1'b1;
`endif

    rf_seq_alu #(.width(width)) alu (
        .a      (operand_a),
        .b      (operand_b),
        .op     (op),
        .result (alu_result)
    );

    // Register-file read data is only valid during EXEC, one edge after the
    // addresses were presented in READ.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            op          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            result      <= '0;
            done_result <= '0;
            done_zero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmdValid) begin
                        op    <= cmdOp;
                        rs1   <= cmdRs1;
                        rs2   <= cmdRs2;
                        rd    <= cmdRd;
                        state <= S_READ;
                    end
                end
                S_READ: state <= S_EXEC;
                S_EXEC: begin
                    result <= alu_result;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    done_result <= result;
                    done_zero   <= (result == '0);
                    state       <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Port values decode straight from state so the write pulse lines up with
    // the register file's own sampling edge.
    assign cmdReady      = (state == S_IDLE);
    assign readRegister1 = rs1;
    assign readRegister2 = rs2;
    assign writeRegister = rd;
    assign writeData     = result;
    assign regWrite      = (state == S_WRITE) && write_allowed;
    assign doneValid     = (state == S_DONE);
    assign doneResult    = done_result;
    assign doneZero      = done_zero;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Bench for rf_alu_sequencer with a behavioural register file and a reference
// model of architectural register state; honours RF_SEQ_X0_HARDWIRE_EN.
module tb_rf_alu_sequencer;

    localparam logic [2:0] T_ADD = 3'd0;
    localparam logic [2:0] T_SUB = 3'd1;
    localparam logic [2:0] T_AND = 3'd2;
    localparam logic [2:0] T_OR  = 3'd3;
    localparam logic [2:0] T_XOR = 3'd4;
    localparam logic [2:0] T_SLT = 3'd5;
    localparam logic [2:0] T_SLL = 3'd6;
    localparam logic [2:0] T_SRL = 3'd7;

    logic        clock;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic [2:0]  cmdOp;
    logic [4:0]  cmdRs1;
    logic [4:0]  cmdRs2;
    logic [4:0]  cmdRd;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic        doneValid;
    logic [31:0] doneResult;
    logic        doneZero;

    logic [31:0] rf    [32];
    logic [31:0] model [32];
    logic [31:0] last_result;
    logic        last_zero;
    int          checks;
    int          failures;

    rf_alu_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .cmdValid      (cmdValid),
        .cmdReady      (cmdReady),
        .cmdOp         (cmdOp),
        .cmdRs1        (cmdRs1),
        .cmdRs2        (cmdRs2),
        .cmdRd         (cmdRd),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .readData1     (readData1),
        .readData2     (readData2),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .regWrite      (regWrite),
        .doneValid     (doneValid),
        .doneResult    (doneResult),
        .doneZero      (doneZero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file with registered reads, as the sequencer expects
    always @(posedge clock) begin
        readData1 <= rf[readRegister1];
        readData2 <= rf[readRegister2];
        if (regWrite) rf[writeRegister] <= writeData;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            T_ADD:   return a + b;
            T_SUB:   return a - b;
            T_AND:   return a & b;
            T_OR:    return a | b;
            T_XOR:   return a ^ b;
            T_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            T_SLL:   return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, {31'd0, cmdReady}, 32'd1);
        checkOutput({tag, "_regwrite"}, {31'd0, regWrite}, 32'd0);
        checkOutput({tag, "_donevalid"}, {31'd0, doneValid}, 32'd0);
        checkOutput({tag, "_rr1"}, {27'd0, readRegister1}, 32'd0);
        checkOutput({tag, "_rr2"}, {27'd0, readRegister2}, 32'd0);
        checkOutput({tag, "_wreg"}, {27'd0, writeRegister}, 32'd0);
        checkOutput({tag, "_wdata"}, writeData, 32'd0);
        checkOutput({tag, "_doneresult"}, doneResult, 32'd0);
        checkOutput({tag, "_donezero"}, {31'd0, doneZero}, 32'd0);
    endtask

    // reset_at: 0 = run to completion, otherwise the busy cycle (1..4) in which reset is raised
    task automatic applyStimulus(input logic [2:0] op, input int rs1, input int rs2, input int rd,
                                 input bit hold_busy, input int reset_at);
        logic [31:0] a, b, expected;
        bit          write_expected;
        int          waited;
        waited = 0;
        @(negedge clock);
        while (!cmdReady && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("ready_at_accept", {31'd0, cmdReady}, 32'd1);
        a = model[rs1];
        b = model[rs2];
        write_expected = 1'b1;
`ifdef RF_SEQ_X0_HARDWIRE_EN
        if (rs1 == 0) a = 32'd0;
        if (rs2 == 0) b = 32'd0;
        if (rd == 0) write_expected = 1'b0;
`endif
        expected = ref_alu(op, a, b);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdRs1   = 5'(rs1);
        cmdRs2   = 5'(rs2);
        cmdRd    = 5'(rd);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clock);
            if (hold_busy) begin
                cmdValid = 1'b1;
                cmdOp    = 3'($urandom);
                cmdRs1   = 5'($urandom);
                cmdRs2   = 5'($urandom);
                cmdRd    = 5'($urandom);
            end else begin
                cmdValid = 1'b0;
            end
            checkOutput("busy_ready", {31'd0, cmdReady}, 32'd0);
            checkOutput("regwrite", {31'd0, regWrite}, {31'd0, (cyc == 3) && write_expected});
            checkOutput("donevalid", {31'd0, doneValid}, {31'd0, cyc == 4});
            if (cyc == 3 && write_expected) begin
                checkOutput("write_reg", {27'd0, writeRegister}, 32'(rd));
                checkOutput("write_data", writeData, expected);
                model[rd] = expected;
            end
            if (cyc == 4) begin
                checkOutput("done_result", doneResult, expected);
                checkOutput("done_zero", {31'd0, doneZero}, {31'd0, expected == 32'd0});
                last_result = doneResult;
                last_zero   = doneZero;
            end
            if (reset_at == cyc) begin
                reset = 1'b1;
                @(negedge clock);
                reset    = 1'b0;
                cmdValid = 1'b0;
                checkResetState("abort");
                checkOutput("abort_rf_rd", rf[rd], model[rd]);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clock);
                    checkOutput("abort_no_write", {31'd0, regWrite}, 32'd0);
                    checkOutput("abort_no_done", {31'd0, doneValid}, 32'd0);
                end
                return;
            end
        end
    endtask

    task automatic checkRegs();
        for (int i = 0; i < 32; i++) checkOutput($sformatf("rf_r%0d", i), rf[i], model[i]);
    endtask

    initial begin
        logic [31:0] r0_before;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        cmdValid = 1'b0;
        cmdOp    = 3'd0;
        cmdRs1   = 5'd0;
        cmdRs2   = 5'd0;
        cmdRd    = 5'd0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[20] = 32'hAAAAAAAA;
        rf[21] = 32'h55555555;
        rf[3]  = 32'd36;
        for (int i = 0; i < 32; i++) model[i] = rf[i];

        repeat (2) @(negedge clock);
        reset = 1'b0;
        checkResetState("reset");

        applyStimulus(T_ADD, 20, 21, 9, 1'b0, 0);
        checkOutput("add_result", last_result, 32'hFFFFFFFF);
        checkOutput("add_zero", {31'd0, last_zero}, 32'd0);
        checkOutput("add_readback_r9", rf[9], 32'hFFFFFFFF);

        applyStimulus(T_SUB, 20, 20, 10, 1'b0, 0);
        checkOutput("sub_result", last_result, 32'h00000000);
        checkOutput("sub_zero", {31'd0, last_zero}, 32'd1);

        applyStimulus(T_SLT, 20, 21, 11, 1'b0, 0);
        checkOutput("slt_result", last_result, 32'd1);

        applyStimulus(T_SRL, 20, 3, 12, 1'b0, 0);
        checkOutput("srl_result", last_result, 32'h0AAAAAAA);

        applyStimulus(T_SLL, 21, 3, 13, 1'b0, 0);
        checkOutput("sll_result", last_result, 32'h55555550);

        // Busy-time commands must be ignored; the next one is taken in the first IDLE cycle
        applyStimulus(T_XOR, 20, 21, 14, 1'b1, 0);
        checkOutput("xor_result", last_result, 32'hFFFFFFFF);
        applyStimulus(T_OR, 20, 3, 15, 1'b0, 0);
        checkOutput("or_result", last_result, 32'hAAAAAAAE);

        applyStimulus(T_ADD, 20, 21, 16, 1'b0, 2);
        applyStimulus(T_SUB, 21, 20, 17, 1'b0, 3);
        checkOutput("write_reset_r17", rf[17], 32'hAAAAAAAB);

        r0_before = model[0];
        applyStimulus(T_ADD, 0, 21, 0, 1'b0, 0);
`ifdef RF_SEQ_X0_HARDWIRE_EN
        checkOutput("x0_result", last_result, 32'h55555555);
        checkOutput("x0_unwritten", rf[0], r0_before);
`else
        checkOutput("r0_result", last_result, r0_before + 32'h55555555);
        checkOutput("r0_written", rf[0], r0_before + 32'h55555555);
`endif
        checkRegs();

        for (int i = 0; i < 24; i++) begin
            bit hold;
            hold = ($urandom_range(0, 1) == 1) && (i != 23);
            applyStimulus(3'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 31)), hold, 0);
        end
        checkRegs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
